// File: rtl/opn_bus_pkg.sv
// Shared constants and types for the OPN CPU write-bus responder.
package opn_bus_pkg;

  // Meaning of the addr pin during a write strobe
  localparam logic ADDR_PHASE = 1'b0;
  localparam logic DATA_PHASE = 1'b1;

  // Bit positions inside the status byte returned on dout
  localparam int unsigned BUSY_BIT  = 7;
  localparam int unsigned OVF_BIT   = 6;
  localparam int unsigned TIMER_LSB = 0;

  // Register addresses also used by the register-init sequencer
  localparam logic [7:0] REG_TIMER_CTRL = 8'h27;
  localparam logic [7:0] REG_KEY_ON     = 8'h28;
  localparam logic [7:0] REG_DT_MUL     = 8'h30;
  localparam logic [7:0] REG_TL         = 8'h40;
  localparam logic [7:0] REG_KS_AR      = 8'h50;
  localparam logic [7:0] REG_AM_DR      = 8'h60;
  localparam logic [7:0] REG_SR         = 8'h70;
  localparam logic [7:0] REG_SL_RR      = 8'h80;
  localparam logic [7:0] REG_SSG_EG     = 8'h90;
  localparam logic [7:0] REG_FNUM_LO    = 8'hA0;
  localparam logic [7:0] REG_FNUM_HI    = 8'hA4;
  localparam logic [7:0] REG_FB_ALG     = 8'hB0;

  // One queued register write
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } fifo_entry_t;

endpackage

// File: rtl/opn_bus_responder_if.sv
// CPU write bus plus the drained register-write stream of the responder.
interface opn_bus_responder_if;

  logic       cs_n;
  logic       wr_n;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_addr;
  logic [7:0] out_data;

  // Host / consumer side
  modport master (
    output cs_n, wr_n, addr, din, out_ready,
    input  dout, out_valid, out_addr, out_data
  );

  // Responder side
  modport slave (
    input  cs_n, wr_n, addr, din, out_ready,
    output dout, out_valid, out_addr, out_data
  );

endinterface

// File: rtl/bus_wr_fifo.sv
// Small synchronous FIFO; push and pop on the same edge are legal when full or empty.
module bus_wr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer separates full from empty
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents need no reset because empty masks them
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  // Pointer update
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/opn_bus_responder.sv
// Responder end of the OPN CPU write bus: pairs address/data writes, queues them
// and returns a registered status byte.
module opn_bus_responder
  import opn_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      cen,
  input  logic [1:0]                timer_flags,
  output logic [7:0]                ovf_cnt,
  opn_bus_responder_if.slave        bus
);

  localparam int unsigned CW = $clog2(BUSY_CYCLES + 1);

  logic          wr_n_q;
  logic [7:0]    addr_latch_q;
  logic [CW-1:0] busy_cnt_q;
  logic          ovf_q;
  logic [7:0]    ovf_cnt_q;
  logic [7:0]    dout_q;
  logic [7:0]    dout_d;

  logic          wr_ev;
  logic          addr_ev;
  logic          data_ev;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          busy;

  logic          fifo_full;
  logic          fifo_empty;
  fifo_entry_t   push_entry;
  fifo_entry_t   head;

  // Falling edge of wr_n with chip select, only on enabled edges
  assign wr_ev   = cen && !bus.cs_n && !bus.wr_n && wr_n_q;
  assign addr_ev = wr_ev && (bus.addr == ADDR_PHASE);
  assign data_ev = wr_ev && (bus.addr == DATA_PHASE);

  // A pop on the same edge frees a slot for a push into a full FIFO
  assign pop     = !fifo_empty && bus.out_ready;
  assign push_ok = data_ev && (!fifo_full || pop);
  assign drop    = data_ev && fifo_full && !pop;

  assign push_entry = '{reg_addr: addr_latch_q, reg_data: bus.din};

  bus_wr_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Head is masked so the outputs read zero whenever nothing is queued
  assign bus.out_valid = !fifo_empty;
  assign bus.out_addr  = fifo_empty ? 8'h00 : head.reg_addr;
  assign bus.out_data  = fifo_empty ? 8'h00 : head.reg_data;

  assign busy = (busy_cnt_q != '0) || !fifo_empty;

  // Status byte assembly
  always_comb begin
    dout_d                       = 8'h00;
    dout_d[BUSY_BIT]             = busy;
    dout_d[OVF_BIT]              = ovf_q;
    dout_d[TIMER_LSB +: 2]       = timer_flags;
  end

  // Strobe history and register-address latch, advanced only on enabled edges
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_n_q       <= 1'b0;
      addr_latch_q <= 8'h00;
    end else begin
      if (cen)     wr_n_q       <= bus.wr_n;
      if (addr_ev) addr_latch_q <= bus.din;
    end
  end

  // Busy hold-off: reload on each accepted data write, count down on enabled edges
  always_ff @(posedge clk_in) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else if (push_ok) begin
      busy_cnt_q <= CW'(BUSY_CYCLES);
    end else if (cen && (busy_cnt_q != '0)) begin
      busy_cnt_q <= busy_cnt_q - CW'(1);
    end
  end

  // Sticky overflow flag and saturating dropped-write counter
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= 8'h00;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  // Registered status output, refreshed every edge
  always_ff @(posedge clk_in) begin
    if (rst) dout_q <= 8'h00;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
  assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: doc/opn_bus_responder.md
Name: opn_bus_responder

Overview:
Responder end of the OPN-style CPU write bus (addr/din/cs_n/wr_n). The register-init sequencer and the host drive this bus.
- addr=0 write: selects the register.
- addr=1 write: carries the data.
The block detects write strobes, pairs each data write with the latched register address and queues the {reg_addr, reg_data} pairs in a small FIFO. The FIFO drains to the synthesizer register file through a valid/ready handshake. Status (busy, overflow, timer flags) is returned on dout.

Parameters:
FIFO_DEPTH, 4, queued write pairs; power of 2, at least 2.
BUSY_CYCLES, 32, cen-qualified cycles for which busy stays asserted after each accepted data write.

Ports:
clk_in  in  1  single clock, 4 MHz domain.
rst  in  1  synchronous, active-high reset.
cen  in  1  clock enable; qualifies bus sampling and the busy counter.
cs_n  in  1  chip select, active low.
wr_n  in  1  write strobe, active low.
addr  in  1  0 = address phase, 1 = data phase.
din  in  8  bus data.
timer_flags  in  2  timer A/B overflow flags, passed to dout[1:0].
dout  out  8  status: {busy, ovf, 4'b0, timer_flags}.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts the head.
out_addr  out  8  register address of the head.
out_data  out  8  register value of the head.
ovf_cnt  out  8  dropped-write count, saturating.

Behaviour:
- All outputs reset to 0: dout=0x00, out_valid=0, out_addr=0, out_data=0, ovf_cnt=0.
- Reset also clears: address latch to 0x00, busy counter, FIFO pointers and the sticky ovf flag. wr_n_q resets to 0, so a wr_n held low across reset release creates no event.
- Edge detect, only on clk_in edges with cen=1:
  - wr_n_q <= wr_n.
  - Write event when cs_n=0, wr_n=0 and wr_n_q=1.
  - addr and din are captured at that same edge.
  - One event per falling edge; holding wr_n low for N cycles gives a single event.
  - With cen=0: no events, wr_n_q holds, busy counter holds.
- Address event (addr=0): address latch <= din. Nothing is pushed; the busy counter is unaffected.
- Data event (addr=1): push {latch, din}.
  - Push when the FIFO is not full, or when it is full and a pop occurs on the same edge (simultaneous push+pop on full is accepted).
  - On an accepted push, busy counter <= BUSY_CYCLES.
  - A data event with no prior address event uses latch 0x00.
  - The latch persists, so repeated data writes reuse the same address.
- Overflow: a data event when full with no pop is dropped. Set sticky ovf and ovf_cnt <= min(ovf_cnt+1, 255). Only rst clears them.
- Output handshake, evaluated every clk_in edge regardless of cen:
  - Pop when out_valid && out_ready.
  - out_addr/out_data show the FIFO head and stay stable while out_valid && !out_ready.
  - Latency: an accepted push into an empty FIFO raises out_valid at the next clk_in edge after the detecting edge.
  - Entries drain in order.
- Busy: busy = (counter != 0) || out_valid.
  - The counter decrements on cen edges and stops at 0.
- dout is registered, updated every edge: {busy, ovf, 4'b0, timer_flags}. It therefore lags its sources by one cycle.
- Reset mid-operation: at the reset edge, queued entries are discarded. out_valid=0 and dout=0x00 on the following cycle; pending address state is lost.

Decomposition:
- Shared package opn_bus_pkg:
  - Phase constants ADDR_PHASE=1'b0, DATA_PHASE=1'b1.
  - dout bit positions: BUSY_BIT=7, OVF_BIT=6, TIMER_LSB=0.
  - Register-address constants shared with the init sequencer (0x27, 0x28, 0x30, 0x40, 0x50, 0x60, 0x70, 0x80, 0x90, 0xA0, 0xA4, 0xB0).
  - The 16-bit FIFO entry type.
- One sub-module: bus_wr_fifo.
  - Synchronous FIFO, parameterized by width/depth.
  - push/pop/full/empty/head; simultaneous push+pop legal when full or empty.
  - Own synchronous rst.

Test Plan:
- Reset, cen=1, out_ready=1; write addr=0 din=0x28, then addr=1 din=0x10 (wr_n low one cycle each):
  - One beat out_addr=0x28, out_data=0x10.
  - dout[7]=1 for 32 cycles after the data edge, then dout=0x00.
- After reset, single data write din=0x3B without an address write -> out_addr=0x00, out_data=0x3B.
- out_ready=0; address 0xA4, then 5 data writes 0x01..0x05:
  - 4 entries held, ovf_cnt=1, dout=0xC0.
  - Raising out_ready drains 0x01..0x04 in order; the 0x05 write was dropped.
- FIFO full, out_ready=1 and a data write detected on the same edge -> push accepted, ovf_cnt unchanged, order preserved.
- wr_n held low 3 cycles with addr=1 -> exactly one entry. Same pulse with cs_n=1 or cen=0 -> no entry.
- Timer flags and reset:
  - timer_flags=2'b10 with idle bus -> dout=0x02 one cycle later.
  - Assert rst with 3 entries queued -> out_valid=0 and dout=0x00 next cycle.
  - wr_n held low across reset release -> no event.
